dma_rw_scheduler: RTL and testbench

DMA_RW_SCHEDULER -- requirements
Module: dma_rw_scheduler

---
 rtl/dma_rw_scheduler.sv | 173 +++++++++++++++++
 tb/tb_dma_rw_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_rw_scheduler.sv
// Arbitrates DDR3 DMA write/read bursts round-robin, walking each channel's
// address pointer through a wrapping frame and guarding every burst with a watchdog.
//
// state    | meaning
// IDLE     | no burst in flight, waiting for calibration and a request
// WR_ISSUE | write command presented for one cycle
// WR_WAIT  | waiting for the write burst-end strobe
// RD_ISSUE | read command presented for one cycle
// RD_WAIT  | counting read beats until BURST_LEN arrive
module dma_rw_scheduler #(
    parameter int          BURST_LEN  = 64,
    parameter int          ADDR_STEP  = 512,
    parameter logic [27:0] WR_BASE    = 28'h0000000,
    parameter logic [27:0] RD_BASE    = 28'h0000000,
    parameter logic [27:0] FRAME_SPAN = 28'h0100000,
    parameter int          TIMEOUT    = 4096
) (
    input  logic        I_Clk,
    input  logic        I_Rst,
    input  logic        I_Calib_Done,
    input  logic        I_Wr_Req,
    input  logic        I_Rd_Req,
    output logic        O_Wr_Start,
    output logic [27:0] O_Wr_Addr,
    output logic [2:0]  O_Wr_Cmd,
    output logic [7:0]  O_Wr_Burst_Len,
    input  logic        I_Wr_Burst_End,
    output logic        O_Rd_Start,
    output logic [27:0] O_Rd_Addr,
    output logic [2:0]  O_Rd_Cmd,
    output logic [7:0]  O_Rd_Burst_Len,
    input  logic        I_Rd_Valid,
    output logic        O_Busy,
    output logic        O_Err,
    output logic        O_Wr_Wrap,
    output logic        O_Rd_Wrap
);

    localparam int             WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);
    localparam logic [7:0]     BEATS   = 8'(BURST_LEN);
    localparam logic [28:0]    STEP    = 29'(ADDR_STEP);
    // Frame limits kept one bit wider so pointer+step cannot overflow the compare
    localparam logic [28:0]    WR_END  = {1'b0, WR_BASE} + {1'b0, FRAME_SPAN};
    localparam logic [28:0]    RD_END  = {1'b0, RD_BASE} + {1'b0, FRAME_SPAN};

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT
    } state_t;

    state_t          state;
    logic [27:0]     wr_ptr;
    logic [27:0]     rd_ptr;
    logic [7:0]      beat_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            last_wr;

    logic [28:0] wr_next;
    logic [28:0] rd_next;
    logic [7:0]  beat_next;

    assign wr_next   = {1'b0, wr_ptr} + STEP;
    assign rd_next   = {1'b0, rd_ptr} + STEP;
    assign beat_next = beat_cnt + 8'd1;

    assign O_Wr_Addr = wr_ptr;
    assign O_Rd_Addr = rd_ptr;
    assign O_Wr_Cmd  = 3'd0;
    assign O_Rd_Cmd  = 3'd1;

    always_ff @(posedge I_Clk) begin
        if (I_Rst) begin
            state          <= IDLE;
            wr_ptr         <= WR_BASE;
            rd_ptr         <= RD_BASE;
            beat_cnt       <= '0;
            wd_cnt         <= '0;
            last_wr        <= 1'b0;
            O_Wr_Start     <= 1'b0;
            O_Rd_Start     <= 1'b0;
            O_Wr_Burst_Len <= '0;
            O_Rd_Burst_Len <= '0;
            O_Wr_Wrap      <= 1'b0;
            O_Rd_Wrap      <= 1'b0;
            O_Busy         <= 1'b0;
            O_Err          <= 1'b0;
        end else begin
            O_Wr_Start     <= 1'b0;
            O_Rd_Start     <= 1'b0;
            O_Wr_Burst_Len <= '0;
            O_Rd_Burst_Len <= '0;
            O_Wr_Wrap      <= 1'b0;
            O_Rd_Wrap      <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_Calib_Done) begin
                        // On a tie, the channel not served last wins
                        if (I_Wr_Req && (!I_Rd_Req || !last_wr)) begin
                            state          <= WR_ISSUE;
                            O_Wr_Start     <= 1'b1;
                            O_Wr_Burst_Len <= BEATS;
                            O_Busy         <= 1'b1;
                        end else if (I_Rd_Req) begin
                            state          <= RD_ISSUE;
                            O_Rd_Start     <= 1'b1;
                            O_Rd_Burst_Len <= BEATS;
                            O_Busy         <= 1'b1;
                        end
                    end
                end
                WR_ISSUE: begin
                    state  <= WR_WAIT;
                    wd_cnt <= WD_LOAD;
                end
                WR_WAIT: begin
                    if (I_Wr_Burst_End) begin
                        if (wr_next >= WR_END) begin
                            wr_ptr    <= WR_BASE;
                            O_Wr_Wrap <= 1'b1;
                        end else begin
                            wr_ptr <= wr_next[27:0];
                        end
                        last_wr <= 1'b1;
                        state   <= IDLE;
                        O_Busy  <= 1'b0;
                    end else if (wd_cnt == '0) begin
                        O_Err   <= 1'b1;
                        last_wr <= 1'b1;
                        state   <= IDLE;
                        O_Busy  <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                RD_ISSUE: begin
                    state    <= RD_WAIT;
                    wd_cnt   <= WD_LOAD;
                    beat_cnt <= '0;
                end
                RD_WAIT: begin
                    if (I_Rd_Valid && (beat_next == BEATS)) begin
                        if (rd_next >= RD_END) begin
                            rd_ptr    <= RD_BASE;
                            O_Rd_Wrap <= 1'b1;
                        end else begin
                            rd_ptr <= rd_next[27:0];
                        end
                        last_wr <= 1'b0;
                        state   <= IDLE;
                        O_Busy  <= 1'b0;
                    end else if (wd_cnt == '0) begin
                        O_Err   <= 1'b1;
                        last_wr <= 1'b0;
                        state   <= IDLE;
                        O_Busy  <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                        if (I_Rd_Valid) beat_cnt <= beat_next;
                    end
                end
                default: begin
                    state  <= IDLE;
                    O_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_rw_scheduler.sv
// Directed self-checking bench for dma_rw_scheduler: default instance for
// arbitration/beats/timeout, a small-frame instance for write-pointer wrap.
module tb_dma_rw_scheduler;

    logic clk = 1'b0;
    logic rst;
    logic calib;
    logic wr_req;
    logic rd_req;
    logic wr_end;
    logic rd_valid;

    logic        a_wr_start, a_rd_start, a_busy, a_err, a_wr_wrap, a_rd_wrap;
    logic [27:0] a_wr_addr, a_rd_addr;
    logic [2:0]  a_wr_cmd, a_rd_cmd;
    logic [7:0]  a_wr_len, a_rd_len;

    logic        b_wr_start, b_rd_start, b_busy, b_err, b_wr_wrap, b_rd_wrap;
    logic [27:0] b_wr_addr, b_rd_addr;
    logic [2:0]  b_wr_cmd, b_rd_cmd;
    logic [7:0]  b_wr_len, b_rd_len;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dma_rw_scheduler dut (
        .I_Clk(clk), .I_Rst(rst), .I_Calib_Done(calib),
        .I_Wr_Req(wr_req), .I_Rd_Req(rd_req),
        .O_Wr_Start(a_wr_start), .O_Wr_Addr(a_wr_addr), .O_Wr_Cmd(a_wr_cmd),
        .O_Wr_Burst_Len(a_wr_len), .I_Wr_Burst_End(wr_end),
        .O_Rd_Start(a_rd_start), .O_Rd_Addr(a_rd_addr), .O_Rd_Cmd(a_rd_cmd),
        .O_Rd_Burst_Len(a_rd_len), .I_Rd_Valid(rd_valid),
        .O_Busy(a_busy), .O_Err(a_err), .O_Wr_Wrap(a_wr_wrap), .O_Rd_Wrap(a_rd_wrap)
    );

    dma_rw_scheduler #(
        .WR_BASE(28'h0000400),
        .FRAME_SPAN(28'h0000400)
    ) dut_wrap (
        .I_Clk(clk), .I_Rst(rst), .I_Calib_Done(calib),
        .I_Wr_Req(wr_req), .I_Rd_Req(rd_req),
        .O_Wr_Start(b_wr_start), .O_Wr_Addr(b_wr_addr), .O_Wr_Cmd(b_wr_cmd),
        .O_Wr_Burst_Len(b_wr_len), .I_Wr_Burst_End(wr_end),
        .O_Rd_Start(b_rd_start), .O_Rd_Addr(b_rd_addr), .O_Rd_Cmd(b_rd_cmd),
        .O_Rd_Burst_Len(b_rd_len), .I_Rd_Valid(rd_valid),
        .O_Busy(b_busy), .O_Err(b_err), .O_Wr_Wrap(b_wr_wrap), .O_Rd_Wrap(b_rd_wrap)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        calib    = 1'b0;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        wr_end   = 1'b0;
        rd_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // sel: 0 = write start, 1 = read start, 2 = wrap-instance write start, 3 = any start
    task automatic wait_start(input int sel, input int max_cyc, output bit found, output int cyc);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < max_cyc) begin
            tick();
            cyc++;
            case (sel)
                0:       found = a_wr_start;
                1:       found = a_rd_start;
                2:       found = b_wr_start;
                default: found = a_wr_start || a_rd_start;
            endcase
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        n_checks++;
        if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", a_err); end
        n_checks++;
        if ({a_wr_start, a_rd_start} !== 2'b00) begin n_fail++; $display("FAIL reset_start: got %b expected 00", {a_wr_start, a_rd_start}); end
        n_checks++;
        if (a_wr_addr !== 28'h0 || a_rd_addr !== 28'h0) begin n_fail++; $display("FAIL reset_addr: got %h/%h expected 0/0", a_wr_addr, a_rd_addr); end
        n_checks++;
        if (a_wr_len !== 8'd0 || a_rd_len !== 8'd0) begin n_fail++; $display("FAIL reset_len: got %0d/%0d expected 0/0", a_wr_len, a_rd_len); end
        n_checks++;
        if (a_wr_cmd !== 3'd0 || a_rd_cmd !== 3'd1) begin n_fail++; $display("FAIL cmd_const: got %0d/%0d expected 0/1", a_wr_cmd, a_rd_cmd); end
        n_checks++;
        if (b_wr_addr !== 28'h400) begin n_fail++; $display("FAIL reset_wr_base: got %h expected 400", b_wr_addr); end
    endtask

    task automatic test_no_calib();
        int  starts = 0;
        bit  busy_seen = 1'b0;
        do_reset();
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (a_wr_start || a_rd_start) starts++;
            if (a_busy) busy_seen = 1'b1;
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        n_checks++;
        if (starts !== 0) begin n_fail++; $display("FAIL no_calib_starts: got %0d expected 0", starts); end
        n_checks++;
        if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL no_calib_busy: got %b expected 0", busy_seen); end
    endtask

    task automatic test_single_write();
        bit found;
        int cyc;
        do_reset();
        calib  = 1'b1;
        wr_req = 1'b1;
        wait_start(0, 20, found, cyc);
        wr_req = 1'b0;
        n_checks++;
        if (!found || cyc != 1) begin n_fail++; $display("FAIL wr_grant: got found=%b cyc=%0d expected found=1 cyc=1", found, cyc); end
        n_checks++;
        if (a_wr_addr !== 28'h0 || a_wr_len !== 8'd64 || a_busy !== 1'b1) begin
            n_fail++; $display("FAIL wr_issue: got addr=%h len=%0d busy=%b expected 0/64/1", a_wr_addr, a_wr_len, a_busy);
        end
        tick();
        n_checks++;
        if (a_wr_start !== 1'b0 || a_wr_len !== 8'd0) begin
            n_fail++; $display("FAIL wr_pulse_width: got start=%b len=%0d expected 0/0", a_wr_start, a_wr_len);
        end
        repeat (5) tick();
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        n_checks++;
        if (a_wr_addr !== 28'd512 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL wr_complete: got addr=%0d busy=%b expected 512/0", a_wr_addr, a_busy);
        end
        // burst-end strobe outside WR_WAIT must not move the pointer
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        tick();
        n_checks++;
        if (a_wr_addr !== 28'd512) begin n_fail++; $display("FAIL wr_end_ignored: got addr=%0d expected 512", a_wr_addr); end
        wr_req = 1'b1;
        wait_start(0, 20, found, cyc);
        wr_req = 1'b0;
        n_checks++;
        if (!found || a_wr_addr !== 28'd512 || a_wr_len !== 8'd64) begin
            n_fail++; $display("FAIL wr_second: got found=%b addr=%0d len=%0d expected 1/512/64", found, a_wr_addr, a_wr_len);
        end
    endtask

    task automatic test_round_robin();
        bit          found;
        int          cyc;
        bit          exp_wr[4];
        logic [27:0] exp_addr[4];
        logic [27:0] got_addr;
        exp_wr   = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_addr = '{28'd0, 28'd0, 28'd512, 28'd512};
        do_reset();
        calib  = 1'b1;
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_start(3, 20, found, cyc);
            got_addr = a_wr_start ? a_wr_addr : a_rd_addr;
            n_checks++;
            if (!found || a_wr_start !== exp_wr[g] || got_addr !== exp_addr[g] || cyc != 1) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got found=%b wr=%b addr=%0d cyc=%0d expected 1/%b/%0d/1",
                         g, found, a_wr_start, got_addr, cyc, exp_wr[g], exp_addr[g]);
            end
            if (!found) break;
            tick();
            if (exp_wr[g]) begin
                wr_end = 1'b1;
                tick();
                wr_end = 1'b0;
            end else begin
                rd_valid = 1'b1;
                repeat (64) tick();
                rd_valid = 1'b0;
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic test_read_beats();
        bit found;
        int cyc;
        do_reset();
        calib  = 1'b1;
        rd_req = 1'b1;
        wait_start(1, 20, found, cyc);
        rd_req = 1'b0;
        n_checks++;
        if (!found || a_rd_len !== 8'd64 || a_rd_addr !== 28'd0) begin
            n_fail++; $display("FAIL rd_issue: got found=%b len=%0d addr=%0d expected 1/64/0", found, a_rd_len, a_rd_addr);
        end
        tick();
        for (int i = 0; i < 64; i++) begin
            if (i == 63) begin
                n_checks++;
                if (a_busy !== 1'b1 || a_rd_addr !== 28'd0) begin
                    n_fail++; $display("FAIL rd_63_beats: got busy=%b addr=%0d expected 1/0", a_busy, a_rd_addr);
                end
            end
            rd_valid = 1'b1;
            tick();
            rd_valid = 1'b0;
            if (i % 4 == 1) repeat (2) tick();
        end
        n_checks++;
        if (a_busy !== 1'b0 || a_rd_addr !== 28'd512) begin
            n_fail++; $display("FAIL rd_64_beats: got busy=%b addr=%0d expected 0/512", a_busy, a_rd_addr);
        end
    endtask

    task automatic test_timeout();
        bit found;
        int cyc;
        rd_req = 1'b1;
        wait_start(1, 20, found, cyc);
        rd_req = 1'b0;
        n_checks++;
        if (!found || a_rd_addr !== 28'd512) begin
            n_fail++; $display("FAIL to_issue: got found=%b addr=%0d expected 1/512", found, a_rd_addr);
        end
        tick();
        for (int c = 1; c <= 4095; c++) begin
            rd_valid = (c <= 63);
            tick();
        end
        rd_valid = 1'b0;
        n_checks++;
        if (a_busy !== 1'b1 || a_err !== 1'b0) begin
            n_fail++; $display("FAIL to_early: got busy=%b err=%b expected 1/0", a_busy, a_err);
        end
        tick();
        n_checks++;
        if (a_busy !== 1'b0 || a_err !== 1'b1 || a_rd_addr !== 28'd512) begin
            n_fail++; $display("FAIL to_expire: got busy=%b err=%b addr=%0d expected 0/1/512", a_busy, a_err, a_rd_addr);
        end
        // timed-out read counts as served, so write wins the next tie
        wr_req = 1'b1;
        rd_req = 1'b1;
        wait_start(3, 20, found, cyc);
        wr_req = 1'b0;
        rd_req = 1'b0;
        n_checks++;
        if (!found || a_wr_start !== 1'b1) begin
            n_fail++; $display("FAIL to_rr: got found=%b wr_start=%b expected 1/1", found, a_wr_start);
        end
        tick();
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        n_checks++;
        if (a_err !== 1'b1 || a_wr_addr !== 28'd512) begin
            n_fail++; $display("FAIL err_sticky: got err=%b wr_addr=%0d expected 1/512", a_err, a_wr_addr);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit found;
        int cyc;
        wr_req = 1'b1;
        wait_start(0, 20, found, cyc);
        wr_req = 1'b0;
        n_checks++;
        if (!found || a_wr_addr !== 28'd512) begin
            n_fail++; $display("FAIL mid_issue: got found=%b addr=%0d expected 1/512", found, a_wr_addr);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (a_busy !== 1'b0 || a_err !== 1'b0 || a_wr_addr !== 28'd0 || a_rd_addr !== 28'd0) begin
            n_fail++; $display("FAIL mid_reset: got busy=%b err=%b wr=%0d rd=%0d expected 0/0/0/0",
                               a_busy, a_err, a_wr_addr, a_rd_addr);
        end
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        n_checks++;
        if (a_wr_addr !== 28'd0 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_after: got wr=%0d busy=%b expected 0/0", a_wr_addr, a_busy);
        end
    endtask

    task automatic test_wrap();
        bit          found;
        int          cyc;
        logic [27:0] exp_addr[2];
        exp_addr = '{28'h400, 28'h600};
        do_reset();
        calib = 1'b1;
        for (int b = 0; b < 2; b++) begin
            wr_req = 1'b1;
            wait_start(2, 20, found, cyc);
            wr_req = 1'b0;
            n_checks++;
            if (!found || b_wr_addr !== exp_addr[b]) begin
                n_fail++; $display("FAIL wrap_issue%0d: got found=%b addr=%h expected 1/%h", b, found, b_wr_addr, exp_addr[b]);
            end
            tick();
            wr_end = 1'b1;
            tick();
            wr_end = 1'b0;
            n_checks++;
            if (b_wr_wrap !== (b == 1)) begin
                n_fail++; $display("FAIL wrap_pulse%0d: got %b expected %b", b, b_wr_wrap, (b == 1));
            end
        end
        n_checks++;
        if (b_wr_addr !== 28'h400) begin n_fail++; $display("FAIL wrap_addr: got %h expected 400", b_wr_addr); end
        tick();
        n_checks++;
        if (b_wr_wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_width: got %b expected 0", b_wr_wrap); end
        wr_req = 1'b1;
        wait_start(2, 20, found, cyc);
        wr_req = 1'b0;
        n_checks++;
        if (!found || b_wr_addr !== 28'h400) begin
            n_fail++; $display("FAIL wrap_next: got found=%b addr=%h expected 1/400", found, b_wr_addr);
        end
    endtask

    initial begin
        test_reset();
        test_no_calib();
        test_single_write();
        test_round_robin();
        test_read_beats();
        test_timeout();
        test_reset_mid_burst();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
